// File: rtl/ir_store_pkg.sv
// Shared encodings for the IR frame store: opcodes, responder FSM states,
// default frame depth. Also used by the global-domain requester.
package ir_store_pkg;

    localparam int unsigned IR_DEPTH_DEF = 1024;

    typedef enum logic [2:0] {
        OP_IDLE    = 3'b000,
        OP_CLEAR   = 3'b001,
        OP_CAPTURE = 3'b010,
        OP_READOUT = 3'b011
    } ir_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUALIFY = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_READ    = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_DONE    = 3'd6
    } ir_state_e;

    function automatic logic ir_op_legal(input logic [2:0] op);
        return (op == OP_CLEAR) || (op == OP_CAPTURE) || (op == OP_READOUT);
    endfunction

endpackage

// File: rtl/ir_addr_counter.sv
// Frame address counter: clears, steps, and saturates at DEPTH-1,
// flagging the terminal count.
module ir_addr_counter
    import ir_store_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = IR_DEPTH_DEF
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_tc
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr <= '0;
        end else if (i_clr) begin
            r_addr <= '0;
        end else if (i_inc && !o_tc) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign o_tc   = (r_addr == LAST);
    assign o_addr = r_addr;

endmodule

// File: rtl/ir_op_responder.sv
// Local-domain responder for CLEAR/CAPTURE/READOUT requests on the frame store.
// Define IR_OP_TIMEOUT_EN to add the CAPTURE idle-stream watchdog.
module ir_op_responder
    import ir_store_pkg::*;
#(
    parameter int unsigned DEPTH       = IR_DEPTH_DEF,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
)(
    input  logic              iClk_Local,
    input  logic              iRst_N,
    input  logic [2:0]        iOp_Code,
    output logic              oOp_Done,
    output logic              oBusy,
    output logic              oErr,
    input  logic [DATA_W-1:0] iPix_Data,
    input  logic              iPix_Valid,
    output logic [ADDR_W-1:0] oMem_Addr,
    output logic              oMem_Wr,
    output logic [DATA_W-1:0] oMem_WrData,
    output logic              oMem_Rd,
    input  logic [DATA_W-1:0] iMem_RdData,
    output logic [DATA_W-1:0] oPix_Data,
    output logic              oPix_Valid
);

    localparam bit CFG_OK = (DEPTH >= 1) && (TIMEOUT_CYC >= 1) &&
                            (64'(DEPTH) <= (64'd1 << ADDR_W));

    if (!CFG_OK) begin : g_bad_cfg
        $error("ir_op_responder: DEPTH must fit ADDR_W, TIMEOUT_CYC >= 1");
    end

    ir_state_e         r_state;
    logic [2:0]        r_op;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_pix_valid;

    logic              w_in_op;
    logic              w_clr;
    logic              w_inc;
    logic              w_tc;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_addr;

    assign w_in_op = (r_state == ST_CLEAR) || (r_state == ST_CAPTURE) ||
                     (r_state == ST_READ);
    assign w_clr   = !w_in_op;
    assign w_inc   = (r_state == ST_CLEAR) || (r_state == ST_READ) ||
                     ((r_state == ST_CAPTURE) && iPix_Valid);

    ir_addr_counter #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr (
        .i_clk   (iClk_Local),
        .i_rst_n (iRst_N),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .o_addr  (w_addr),
        .o_tc    (w_tc)
    );

`ifdef IR_OP_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_idle;

    always_ff @(posedge iClk_Local or negedge iRst_N) begin
        if (!iRst_N) begin
            r_idle <= '0;
        end else if ((r_state != ST_CAPTURE) || iPix_Valid) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + TO_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYC-th consecutive empty cycle.
    assign w_timeout = (r_state == ST_CAPTURE) && !iPix_Valid &&
                       (r_idle == TO_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge iClk_Local or negedge iRst_N) begin
        if (!iRst_N) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= (r_state == ST_READ);
            unique case (r_state)
                ST_IDLE: begin
                    if (iOp_Code != OP_IDLE) begin
                        r_op    <= iOp_Code;
                        r_state <= ST_QUALIFY;
                    end
                end
                ST_QUALIFY: begin
                    // Two equal samples in a row reject synchronizer skew.
                    if (iOp_Code == OP_IDLE) begin
                        r_state <= ST_IDLE;
                    end else if (iOp_Code != r_op) begin
                        r_op <= iOp_Code;
                    end else if (!ir_op_legal(r_op)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_busy <= 1'b1;
                        if (r_op == OP_CLEAR) begin
                            r_state <= ST_CLEAR;
                        end else if (r_op == OP_CAPTURE) begin
                            r_state <= ST_CAPTURE;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (w_tc) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (w_timeout) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else if (iPix_Valid && w_tc) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (w_tc) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    if (iOp_Code == OP_IDLE) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oOp_Done    = r_done;
    assign oBusy       = r_busy;
    assign oErr        = r_err;
    assign oMem_Addr   = w_addr;
    assign oMem_Wr     = (r_state == ST_CLEAR) ||
                         ((r_state == ST_CAPTURE) && iPix_Valid);
    assign oMem_WrData = (r_state == ST_CAPTURE) ? iPix_Data : '0;
    assign oMem_Rd     = (r_state == ST_READ);

    // Read data already comes from the memory's output register.
    assign oPix_Valid  = r_pix_valid;
    assign oPix_Data   = r_pix_valid ? iMem_RdData : '0;

endmodule

// File: tb/tb_ir_op_responder.sv
// Directed bench for ir_op_responder (DEPTH=16, TIMEOUT_CYC=8).
// Table-driven opcode runs plus hand sequences for handshake and reset cases.
module tb_ir_op_responder;

    logic        clk = 1'b0;
    logic        iRst_N;
    logic [2:0]  iOp_Code;
    logic        oOp_Done, oBusy, oErr;
    logic [15:0] iPix_Data;
    logic        iPix_Valid;
    logic [3:0]  oMem_Addr;
    logic        oMem_Wr, oMem_Rd;
    logic [15:0] oMem_WrData;
    logic [15:0] iMem_RdData;
    logic [15:0] oPix_Data;
    logic        oPix_Valid;

    always #5 clk = ~clk;

    ir_op_responder #(
        .DEPTH(16), .ADDR_W(4), .DATA_W(16), .TIMEOUT_CYC(8)
    ) dut (
        .iClk_Local  (clk),
        .iRst_N      (iRst_N),
        .iOp_Code    (iOp_Code),
        .oOp_Done    (oOp_Done),
        .oBusy       (oBusy),
        .oErr        (oErr),
        .iPix_Data   (iPix_Data),
        .iPix_Valid  (iPix_Valid),
        .oMem_Addr   (oMem_Addr),
        .oMem_Wr     (oMem_Wr),
        .oMem_WrData (oMem_WrData),
        .oMem_Rd     (oMem_Rd),
        .iMem_RdData (iMem_RdData),
        .oPix_Data   (oPix_Data),
        .oPix_Valid  (oPix_Valid)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model, 1-cycle read latency
    logic [15:0] mem [16];
    logic [15:0] mem_q = '0;
    logic        load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'(i * 3);
        end else if (oMem_Wr) begin
            mem[oMem_Addr] <= oMem_WrData;
        end
        if (oMem_Rd) mem_q <= mem[oMem_Addr];
    end
    assign iMem_RdData = mem_q;

    // Pixel source: mode 1 = 16 beats with two 3-cycle gaps, mode 2 = 5 beats then silence
    int  feed_mode = 0;
    int  fp = 0;
    int  fb = 0;
    logic pat [22];

    always @(posedge clk) begin
        #1;
        if (feed_mode != 0 && oBusy && (feed_mode == 2 || fp < 22)) begin
            iPix_Valid = (feed_mode == 1) ? pat[fp] : (fp < 5);
            iPix_Data  = 16'hA000 + 16'(fb);
            if (iPix_Valid) fb++;
            fp++;
        end else begin
            iPix_Valid = 1'b0;
            iPix_Data  = '0;
            if (feed_mode == 0) begin
                fp = 0;
                fb = 0;
            end
        end
    end

    // Monitor
    logic [15:0] wa_q[$], wd_q[$], ra_q[$], pd_q[$];
    int          wc_q[$], rc_q[$], pc_q[$];
    int          both_cnt = 0;
    logic        busy_seen = 1'b0;

    always @(negedge clk) begin
        if (iRst_N) begin
            if (oMem_Wr && oMem_Rd) both_cnt++;
            if (oMem_Wr) begin
                wa_q.push_back(16'(oMem_Addr));
                wd_q.push_back(oMem_WrData);
                wc_q.push_back(cyc);
            end
            if (oMem_Rd) begin
                ra_q.push_back(16'(oMem_Addr));
                rc_q.push_back(cyc);
            end
            if (oPix_Valid) begin
                pd_q.push_back(oPix_Data);
                pc_q.push_back(cyc);
            end
            if (oBusy) busy_seen = 1'b1;
        end
    end

    task automatic clr_log();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        ra_q.delete(); rc_q.delete();
        pd_q.delete(); pc_q.delete();
        busy_seen = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_done(input int lim, output int dc);
        dc = -1;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (oOp_Done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            n_chk++;
            n_err++;
            $display("FAIL done_timeout: oOp_Done still 0 after %0d cycles", lim);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] op0;
        logic [2:0] op;
        int         feed;
        int         n_wr;
        int         n_rd;
        int         lat;
        logic       err;
    } vec_t;

    vec_t vt [7];

    initial begin
        vec_t v;
        int   c0;
        int   dc;
        int   ok;

        for (int i = 0; i < 22; i++) pat[i] = !((i >= 5 && i < 8) || (i >= 14 && i < 17));

        vt[0] = '{3'b111, 3'b111, 0,  0,  0,  2, 1'b1};
        vt[1] = '{3'b001, 3'b001, 0, 16,  0, 18, 1'b0};
        vt[2] = '{3'b010, 3'b010, 1, 16,  0, 24, 1'b0};
        vt[3] = '{3'b011, 3'b011, 0,  0, 16, 19, 1'b0};
        vt[4] = '{3'b011, 3'b010, 1, 16,  0, 25, 1'b0};
        vt[5] = '{3'b100, 3'b100, 0,  0,  0,  2, 1'b1};
        vt[6] = '{3'b110, 3'b110, 0,  0,  0,  2, 1'b1};

        iRst_N   = 1'b0;
        iOp_Code = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done",  32'(oOp_Done),   0);
        chk("rst_busy",  32'(oBusy),      0);
        chk("rst_err",   32'(oErr),       0);
        chk("rst_addr",  32'(oMem_Addr),  0);
        chk("rst_wr",    32'(oMem_Wr),    0);
        chk("rst_rd",    32'(oMem_Rd),    0);
        chk("rst_pixv",  32'(oPix_Valid), 0);
        tick();
        iRst_N = 1'b1;
        @(negedge clk);
        chk("post_rst_access", 32'(oMem_Wr | oMem_Rd), 0);
        tick();

        for (int r = 0; r < 7; r++) begin
            v = vt[r];
            if (v.n_rd != 0) begin
                load_req = 1'b1;
                tick();
                load_req = 1'b0;
            end
            clr_log();
            feed_mode = v.feed;
            iOp_Code  = v.op0;
            c0        = cyc;
            if (v.op0 != v.op) begin
                tick();
                iOp_Code = v.op;
            end
            wait_done(200, dc);
            chk($sformatf("v%0d_latency", r), 32'(dc - c0), 32'(v.lat));
            chk($sformatf("v%0d_err", r),     32'(oErr),    32'(v.err));
            chk($sformatf("v%0d_busy_off", r), 32'(oBusy),  0);
            chk($sformatf("v%0d_busy_seen", r), 32'(busy_seen), 32'(v.n_wr + v.n_rd > 0));
            chk($sformatf("v%0d_nwr", r), 32'(wa_q.size()), 32'(v.n_wr));
            chk($sformatf("v%0d_nrd", r), 32'(ra_q.size()), 32'(v.n_rd));
            chk($sformatf("v%0d_npix", r), 32'(pd_q.size()), 32'(v.n_rd));
            for (int i = 0; i < wa_q.size(); i++) begin
                chk($sformatf("v%0d_wr_addr%0d", r, i), 32'(wa_q[i]), 32'(i));
                chk($sformatf("v%0d_wr_data%0d", r, i), 32'(wd_q[i]),
                    (v.op == 3'b001) ? 32'h0 : 32'(16'hA000 + 16'(i)));
                if (i > 0 && v.op == 3'b001)
                    chk($sformatf("v%0d_wr_consec%0d", r, i), 32'(wc_q[i]), 32'(wc_q[i-1] + 1));
            end
            if (v.n_wr != 0 && wc_q.size() != 0)
                chk($sformatf("v%0d_done_after_wr", r), 32'(dc), 32'(wc_q[wc_q.size()-1] + 1));
            for (int i = 0; i < ra_q.size(); i++) begin
                chk($sformatf("v%0d_rd_addr%0d", r, i), 32'(ra_q[i]), 32'(i));
                if (i > 0)
                    chk($sformatf("v%0d_rd_consec%0d", r, i), 32'(rc_q[i]), 32'(rc_q[i-1] + 1));
            end
            for (int i = 0; i < pd_q.size(); i++) begin
                chk($sformatf("v%0d_pix%0d", r, i), 32'(pd_q[i]), 32'(3 * i));
                if (i < rc_q.size())
                    chk($sformatf("v%0d_pix_lat%0d", r, i), 32'(pc_q[i]), 32'(rc_q[i] + 1));
            end
            feed_mode = 0;
            @(negedge clk);
            chk($sformatf("v%0d_done_hold", r), 32'(oOp_Done), 1);
            tick();
            iOp_Code = 3'b000;
            @(negedge clk);
            chk($sformatf("v%0d_done_still", r), 32'(oOp_Done), 1);
            @(negedge clk);
            chk($sformatf("v%0d_done_clr", r), 32'(oOp_Done), 0);
            chk($sformatf("v%0d_err_clr", r),  32'(oErr), 0);
            tick();
        end

        // Opcode dropped while busy: ignored, and DONE lasts one cycle
        clr_log();
        iOp_Code = 3'b001;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (oBusy) begin
                ok = 1;
                break;
            end
        end
        chk("seqA_busy", 32'(ok), 1);
        tick();
        iOp_Code = 3'b000;
        wait_done(50, dc);
        chk("seqA_nwr", 32'(wa_q.size()), 16);
        chk("seqA_err", 32'(oErr), 0);
        @(negedge clk);
        chk("seqA_done_1cyc", 32'(oOp_Done), 0);
        tick();

        // New opcode while DONE must not start anything
        clr_log();
        iOp_Code = 3'b001;
        wait_done(50, dc);
        tick();
        iOp_Code = 3'b010;
        feed_mode = 1;
        repeat (4) @(negedge clk);
        chk("seqB_done_hold", 32'(oOp_Done), 1);
        chk("seqB_busy", 32'(oBusy), 0);
        chk("seqB_nwr", 32'(wa_q.size()), 16);
        tick();
        iOp_Code = 3'b000;
        feed_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("seqB_done_clr", 32'(oOp_Done), 0);
        repeat (3) @(negedge clk);
        chk("seqB_idle_nwr", 32'(wa_q.size()), 16);
        tick();

`ifdef IR_OP_TIMEOUT_EN
        clr_log();
        feed_mode = 2;
        iOp_Code  = 3'b010;
        c0        = cyc;
        wait_done(100, dc);
        chk("to_latency", 32'(dc - c0), 15);
        chk("to_err", 32'(oErr), 1);
        chk("to_nwr", 32'(wa_q.size()), 5);
        feed_mode = 0;
        tick();
        iOp_Code = 3'b000;
        repeat (2) @(negedge clk);
        chk("to_done_clr", 32'(oOp_Done), 0);
        chk("to_nwr_after", 32'(wa_q.size()), 5);
        tick();
`endif

        // Reset in the middle of a READ
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        iOp_Code = 3'b011;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (oMem_Rd && oMem_Addr == 4'd7) begin
                ok = 1;
                break;
            end
        end
        chk("seqR_reach7", 32'(ok), 1);
        iRst_N = 1'b0;
        #1;
        chk("seqR_rd",   32'(oMem_Rd),    0);
        chk("seqR_wr",   32'(oMem_Wr),    0);
        chk("seqR_addr", 32'(oMem_Addr),  0);
        chk("seqR_busy", 32'(oBusy),      0);
        chk("seqR_done", 32'(oOp_Done),   0);
        chk("seqR_pixv", 32'(oPix_Valid), 0);
        chk("seqR_pixd", 32'(oPix_Data),  0);
        tick();
        clr_log();
        iRst_N = 1'b1;
        c0 = cyc;
        @(negedge clk);
        chk("seqR_first_cyc", 32'(oMem_Wr | oMem_Rd), 0);
        wait_done(60, dc);
        chk("seqR_latency", 32'(dc - c0), 19);
        chk("seqR_nrd", 32'(ra_q.size()), 16);
        if (ra_q.size() == 16) begin
            chk("seqR_rd_first", 32'(ra_q[0]), 0);
            chk("seqR_rd_last", 32'(ra_q[15]), 15);
        end
        chk("seqR_npix", 32'(pd_q.size()), 16);
        if (pd_q.size() == 16)
            chk("seqR_pix_last", 32'(pd_q[15]), 45);
        tick();
        iOp_Code = 3'b000;
        repeat (2) @(negedge clk);
        chk("seqR_done_clr", 32'(oOp_Done), 0);

        chk("wr_rd_exclusive", 32'(both_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
